aurora_rx_deframer: RTL and testbench

AURORA_RX_DEFRAMER -- requirements
Module: aurora_rx_deframer

---
 rtl/aurora_rx_deframer.sv | 208 ++++++++++++++++++++
 tb/tb_aurora_rx_deframer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_deframer.sv
// Aurora RX deframer: 3-word frames into a small packet FIFO.
// Optional head timestamps: define AURORA_RX_TIMESTAMP_EN.
module aurora_rx_deframer #(
  parameter int PKT_WORDS = 3,
  parameter int FIFO_PKTS = 4
) (
  input  logic                       io_clk,
  input  logic                       reset,
  input  logic [0:31]                rx_data,
  input  logic                       rx_tvalid,
  input  logic [3:0]                 rx_tkeep,
  input  logic                       rx_tlast,
  input  logic                       channel_up,
  input  logic                       pkt_rd,
  output logic                       pkt_avail,
  output logic [0:31]                pkt_word0,
  output logic [0:31]                pkt_word1,
  output logic [0:31]                pkt_word2,
  output logic [$clog2(FIFO_PKTS):0] pkt_count,
  output logic [15:0]                err_len_cnt,
  output logic [15:0]                err_ovf_cnt,
  output logic [31:0]                pkt_tstamp
);

  localparam int AW = $clog2(FIFO_PKTS);
  localparam int CW = AW + 1;
  localparam int PW = PKT_WORDS * 32;

  typedef logic [PW-1:0] pkt_t;

  typedef enum logic [1:0] {
    S_W0,
    S_W1,
    S_W2,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [0:31]   w0_q, w0_d;
  logic [0:31]   w1_q, w1_d;
  logic          bad_q, bad_d;
  logic          len_err;
  logic          commit;
  logic          key_bad;

  pkt_t          mem_q [FIFO_PKTS];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   len_q, ovf_q;
  logic          full, empty;
  logic          push, pop;

  assign key_bad = (rx_tkeep != 4'hF);
  assign full    = (cnt_q == CW'(FIFO_PKTS));
  assign empty   = (cnt_q == '0);
  assign pop     = pkt_rd && !empty;
  assign push    = commit && (!full || pop);

  // Frame FSM state and word capture registers
  always_ff @(posedge io_clk) begin
    if (!reset) begin
      state_q <= S_W0;
      w0_q    <= '0;
      w1_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      bad_q   <= bad_d;
    end
  end

  // Next state, word capture, length errors and commit
  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    bad_d   = bad_q;
    len_err = 1'b0;
    commit  = 1'b0;
    if (!channel_up) begin
      state_d = S_W0;
    end else if (rx_tvalid) begin
      unique case (state_q)
        S_W0: begin
          w0_d  = rx_data;
          bad_d = key_bad;
          if (rx_tlast) begin
            len_err = 1'b1;
          end else begin
            state_d = S_W1;
          end
        end
        S_W1: begin
          w1_d  = rx_data;
          bad_d = bad_q | key_bad;
          if (rx_tlast) begin
            len_err = 1'b1;
            state_d = S_W0;
          end else begin
            state_d = S_W2;
          end
        end
        S_W2: begin
          bad_d = bad_q | key_bad;
          if (rx_tlast) begin
            state_d = S_W0;
            if (bad_q || key_bad) begin
              len_err = 1'b1;
            end else begin
              commit = 1'b1;
            end
          end else begin
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (rx_tlast) begin
            len_err = 1'b1;
            state_d = S_W0;
          end
        end
      endcase
    end
  end

  // Packet FIFO storage, pointers and occupancy
  always_ff @(posedge io_clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_PKTS; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {w0_q, w1_q, rx_data};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Saturating error counters
  always_ff @(posedge io_clk) begin
    if (!reset) begin
      len_q <= '0;
      ovf_q <= '0;
    end else begin
      if (len_err && len_q != 16'hFFFF) begin
        len_q <= len_q + 16'd1;
      end
      if (commit && !push && ovf_q != 16'hFFFF) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  assign pkt_avail   = !empty;
  assign pkt_count   = cnt_q;
  assign err_len_cnt = len_q;
  assign err_ovf_cnt = ovf_q;
  assign pkt_word0   = mem_q[rd_q][PW-1 -: 32];
  assign pkt_word1   = mem_q[rd_q][PW-33 -: 32];
  assign pkt_word2   = mem_q[rd_q][31:0];

`ifdef AURORA_RX_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts0_q;
  logic [31:0] tmem_q [FIFO_PKTS];
  logic        take0;

  assign take0 = channel_up && rx_tvalid && (state_q == S_W0);

  // Free-running stamp, word-0 capture and per-packet stamp storage
  always_ff @(posedge io_clk) begin
    if (!reset) begin
      ts_q  <= '0;
      ts0_q <= '0;
      for (int i = 0; i < FIFO_PKTS; i++) begin
        tmem_q[i] <= '0;
      end
    end else begin
      ts_q <= ts_q + 32'd1;
      if (take0) begin
        ts0_q <= ts_q;
      end
      if (push) begin
        tmem_q[wr_q] <= ts0_q;
      end
    end
  end

  assign pkt_tstamp = tmem_q[rd_q];
`else
  assign pkt_tstamp = 32'h0;
`endif

endmodule

// File: tb/tb_aurora_rx_deframer.sv
// Self-checking bench for aurora_rx_deframer.
// Scoreboard queue of expected packets plus a vector table.
module tb_aurora_rx_deframer;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [0:31] rx_data;
  logic        rx_tvalid;
  logic [3:0]  rx_tkeep;
  logic        rx_tlast;
  logic        channel_up;
  logic        pkt_rd;
  logic        pkt_avail;
  logic [0:31] pkt_word0, pkt_word1, pkt_word2;
  logic [2:0]  pkt_count;
  logic [15:0] err_len_cnt, err_ovf_cnt;
  logic [31:0] pkt_tstamp;

  always #5 io_clk = ~io_clk;

  aurora_rx_deframer #(.PKT_WORDS(3), .FIFO_PKTS(4)) dut (
    .io_clk(io_clk), .reset(reset), .rx_data(rx_data),
    .rx_tvalid(rx_tvalid), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .channel_up(channel_up), .pkt_rd(pkt_rd), .pkt_avail(pkt_avail),
    .pkt_word0(pkt_word0), .pkt_word1(pkt_word1), .pkt_word2(pkt_word2),
    .pkt_count(pkt_count), .err_len_cnt(err_len_cnt),
    .err_ovf_cnt(err_ovf_cnt), .pkt_tstamp(pkt_tstamp)
  );

  typedef logic [95:0] pkt_t;
  pkt_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_len  = 0;
  int   m_ovf  = 0;

  typedef struct {
    int nw;
    int bad;
    int gap;
    bit pop;
    int exp_cnt;
    int exp_len;
  } vec_t;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic pkt_t head();
    return {pkt_word0, pkt_word1, pkt_word2};
  endfunction

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic word(input logic [31:0] d, input logic [3:0] k,
                      input logic l, input bit rd);
    rx_data   = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    rx_tvalid = 1'b1;
    pkt_rd    = rd;
    tick();
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    pkt_rd    = 1'b0;
  endtask

  task automatic frame(input int nw, input int bad, input int gap,
                       input logic [31:0] base, input bit rd_last);
    bit   good;
    pkt_t p;
    good = (nw == 3) && (bad < 0);
    p = {32'(base + 1), 32'(base + 2), 32'(base + 3)};
    for (int i = 0; i < nw; i++) begin
      if (i == nw - 1 && rd_last && exp_q.size() > 0)
        chk("head_at_rd", head(), exp_q[0]);
      word(32'(base + 32'(i) + 1), (i == bad) ? 4'h7 : 4'hF,
           i == nw - 1, rd_last && i == nw - 1);
      if (i < nw - 1) repeat (gap) tick();
    end
    if (rd_last && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!good) m_len++;
    else if (exp_q.size() < 4) exp_q.push_back(p);
    else m_ovf++;
  endtask

  task automatic pop_chk(input string nm);
    if (exp_q.size() == 0) begin
      chk({nm, "_empty_avail"}, 96'(pkt_avail), 96'd0);
    end else begin
      chk({nm, "_avail"}, 96'(pkt_avail), 96'd1);
      chk({nm, "_head"}, head(), exp_q[0]);
      void'(exp_q.pop_front());
    end
    pkt_rd = 1'b1;
    tick();
    pkt_rd = 1'b0;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, 96'(pkt_count), 96'(exp_q.size()));
    chk({nm, "_len"}, 96'(err_len_cnt), 96'(m_len));
    chk({nm, "_ovf"}, 96'(err_ovf_cnt), 96'(m_ovf));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_avail"}, 96'(pkt_avail), 96'd0);
    chk({nm, "_count"}, 96'(pkt_count), 96'd0);
    chk({nm, "_words"}, head(), 96'd0);
    chk({nm, "_errs"}, 96'({err_len_cnt, err_ovf_cnt}), 96'd0);
    chk({nm, "_tstamp"}, 96'(pkt_tstamp), 96'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    m_len = 0;
    m_ovf = 0;
    reset = 1'b1;
  endtask

  vec_t vt[11];
  pkt_t p41;

  initial begin
    vt[0]  = '{3, -1, 0, 1'b0, 1, 0};
    vt[1]  = '{2, -1, 1, 1'b0, 1, 1};
    vt[2]  = '{5, -1, 0, 1'b0, 1, 2};
    vt[3]  = '{3,  1, 0, 1'b0, 1, 3};
    vt[4]  = '{3, -1, 2, 1'b1, 1, 3};
    vt[5]  = '{1, -1, 0, 1'b0, 1, 4};
    vt[6]  = '{4, -1, 3, 1'b0, 1, 5};
    vt[7]  = '{3,  0, 1, 1'b0, 1, 6};
    vt[8]  = '{3,  2, 0, 1'b0, 1, 7};
    vt[9]  = '{3, -1, 3, 1'b0, 2, 7};
    vt[10] = '{3, -1, 1, 1'b1, 2, 7};

    reset      = 1'b0;
    rx_data    = '0;
    rx_tvalid  = 1'b0;
    rx_tkeep   = 4'hF;
    rx_tlast   = 1'b0;
    channel_up = 1'b1;
    pkt_rd     = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();

    // pop while empty is ignored
    pkt_rd = 1'b1;
    tick();
    pkt_rd = 1'b0;
    chk("rd_empty_count", 96'(pkt_count), 96'd0);

    // basic frame, visible the cycle after tlast
    word(32'h11111111, 4'hF, 1'b0, 1'b0);
    word(32'h22222222, 4'hF, 1'b0, 1'b0);
    word(32'h33333333, 4'hF, 1'b1, 1'b0);
    p41 = {32'h11111111, 32'h22222222, 32'h33333333};
    exp_q.push_back(p41);
    chk("basic_avail", 96'(pkt_avail), 96'd1);
    chk("basic_count", 96'(pkt_count), 96'd1);
    pop_chk("basic");
    chk("basic_after_rd", 96'(pkt_avail), 96'd0);

    // short and long frames
    word(32'hAAAA0001, 4'hF, 1'b0, 1'b0);
    word(32'hAAAA0002, 4'hF, 1'b1, 1'b0);
    m_len++;
    frame(5, -1, 0, 32'hBBBB0000, 1'b0);
    chk("len2_len", 96'(err_len_cnt), 96'd2);
    chk("len2_count", 96'(pkt_count), 96'd0);
    frame(3, -1, 0, 32'hCCCC0000, 1'b0);
    chk_state("len2_good");
    pop_chk("len2_good");

    // overflow then simultaneous commit+pop while full
    for (int f = 1; f <= 6; f++) frame(3, -1, 0, 32'(f) << 16, 1'b0);
    chk("ovf_count", 96'(pkt_count), 96'd4);
    chk("ovf_cnt", 96'(err_ovf_cnt), 96'd2);
    chk("ovf_head", head(), {32'h00010001, 32'h00010002, 32'h00010003});
    frame(3, -1, 0, 32'h00070000, 1'b1);
    chk("full_rdwr_count", 96'(pkt_count), 96'd4);
    chk("full_rdwr_head", head(), {32'h00020001, 32'h00020002, 32'h00020003});
    chk_state("full_rdwr");
    while (exp_q.size() > 0) pop_chk("drain1");
    chk_state("drain1");

    // vector table: lengths, bad tkeep, gaps, pops
    do_reset();
    for (int i = 0; i < 11; i++) begin
      frame(vt[i].nw, vt[i].bad, vt[i].gap, 32'(i + 1) << 20, 1'b0);
      if (vt[i].pop) pop_chk($sformatf("vec%0d_pop", i));
      chk($sformatf("vec%0d_count", i), 96'(pkt_count), 96'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_len", i), 96'(err_len_cnt), 96'(vt[i].exp_len));
      chk($sformatf("vec%0d_model", i), 96'(pkt_count), 96'(exp_q.size()));
    end
    while (exp_q.size() > 0) pop_chk("drain2");
    chk_state("drain2");

    // channel drop mid-frame
    word(32'hD0000001, 4'hF, 1'b0, 1'b0);
    channel_up = 1'b0;
    tick();
    channel_up = 1'b1;
    frame(3, -1, 0, 32'hE0000000, 1'b0);
    chk_state("chan");
    pop_chk("chan");

    // reset mid-frame with two packets queued
    frame(3, -1, 0, 32'hF1000000, 1'b0);
    frame(3, -1, 0, 32'hF2000000, 1'b0);
    word(32'hF3000001, 4'hF, 1'b0, 1'b0);
    word(32'hF3000002, 4'hF, 1'b0, 1'b0);
    reset = 1'b0;
    rx_data = 32'hDEADBEEF;
    rx_tvalid = 1'b1;
    rx_tlast = 1'b1;
    tick();
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    chk_zero("rst_mid");
    reset = 1'b1;
    exp_q.delete();
    m_len = 0;
    m_ovf = 0;
    frame(3, -1, 0, 32'hF4000000, 1'b0);
    chk_state("rst_fresh");
    pop_chk("rst_fresh");

`ifdef AURORA_RX_TIMESTAMP_EN
    begin
      logic [31:0] t0;
      frame(3, -1, 0, 32'h70000000, 1'b0);
      repeat (97) tick();
      frame(3, -1, 0, 32'h71000000, 1'b0);
      t0 = pkt_tstamp;
      pop_chk("ts_a");
      chk("ts_delta", 96'(pkt_tstamp - t0), 96'd100);
      pop_chk("ts_b");
    end
`else
    frame(3, -1, 0, 32'h70000000, 1'b0);
    chk("ts_off", 96'(pkt_tstamp), 96'd0);
    pop_chk("ts_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
